rom_string_streamer: RTL and testbench

- Sequences a combinational character ROM (4-bit address, 8-bit data) and streams its contents as a byte stream to a downstream consumer, such as a UART transmitter or a display writer, over a valid/ready handshake.
- A start pulse walks addresses from 0 upward.
- The stream ends at the first 0x00 terminator or after the last address.
- Also reports busy, done and the count of characters sent.

---
 rtl/rom_string_streamer.sv | 121 ++++++++++++
 tb/tb_rom_string_streamer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_string_streamer.sv
// Walks a combinational character ROM from address 0 and streams each byte over
// a valid/ready port until a terminator byte or the last address is reached.
module rom_string_streamer #(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] TERM   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   char_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_valid, w_valid_nxt;
    logic [ADDR_W:0]     r_count, w_count_nxt;

    // Output handshake: a byte transfers on a rising edge where out_valid && out_ready.
    // Once raised, out_valid stays high and out_data stays fixed until that transfer
    // (only abort or reset may withdraw it).
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (start) begin
                    w_addr_nxt  = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (rom_data == TERM) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_data_nxt  = rom_data;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // abort wins even over a handshake landing on the same edge
                if (abort) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_count_nxt = r_count + CNT_ONE;
                    if (r_addr == ADDR_MAX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign rom_addr   = r_addr;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign char_count = r_count;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_rom_string_streamer.sv
// Directed bench for rom_string_streamer: a ROM array in the bench feeds the DUT,
// and each scenario task checks the stream, timing and status against hand values.
module tb_rom_string_streamer;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] char_count;
    logic [1:0] dbg_state;

    logic [7:0] rom [0:15];
    assign rom_data = rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         first_valid_edge;
    int         done_edge;
    int         done_pulses;
    int         hold_errs;
    bit         timed_out;
    logic [4:0] end_count;
    logic [3:0] end_addr;

    rom_string_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .char_count (char_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic load_student();
        for (int i = 0; i < 16; i++) rom[i] = 8'h5A;
        rom[0] = 8'h53; rom[1] = 8'h54; rom[2] = 8'h55; rom[3] = 8'h44;
        rom[4] = 8'h45; rom[5] = 8'h4E; rom[6] = 8'h54; rom[7] = 8'h00;
        exp_q = '{8'h53, 8'h54, 8'h55, 8'h44, 8'h45, 8'h4E, 8'h54};
    endtask

    // Starts a run and records what the consumer sees; edge 1 is the edge that samples start.
    task automatic run_stream(input int ready_pct, input int max_edges);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        first_valid_edge = -1;
        done_edge        = -1;
        done_pulses      = 0;
        hold_errs        = 0;
        timed_out        = 1'b1;
        prev_stall       = 1'b0;
        prev_data        = '0;
        end_count        = '0;
        end_addr         = '0;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (ready_pct >= 100);
        for (int e = 1; e <= max_edges; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (prev_stall && (!out_valid || out_data !== prev_data)) hold_errs++;
            if (out_valid && first_valid_edge < 0) first_valid_edge = e;
            if (done) begin
                done_pulses++;
                if (done_edge < 0) begin
                    done_edge = e;
                    end_count = char_count;
                    end_addr  = rom_addr;
                end
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) got_q.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done_edge >= 0 && e >= done_edge + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0h want 0", rom_addr); end
        n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (char_count !== 5'd0) begin n_fail++; $display("FAIL reset_char_count got %0d want 0", char_count); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_student();
        load_student();
        run_stream(100, 60);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL student_timeout got no done want done"); end
        n_checks++; if (got_q.size() != 7) begin n_fail++; $display("FAIL student_len got %0d want 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL student_byte%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (first_valid_edge != 2) begin n_fail++; $display("FAIL student_first_valid got edge %0d want 2", first_valid_edge); end
        n_checks++; if (done_edge != 16) begin n_fail++; $display("FAIL student_done_edge got %0d want 16", done_edge); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL student_done_pulses got %0d want 1", done_pulses); end
        n_checks++; if (end_count !== 5'd7) begin n_fail++; $display("FAIL student_count got %0d want 7", end_count); end
        n_checks++; if (end_addr !== 4'd7) begin n_fail++; $display("FAIL student_addr got %0d want 7", end_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL student_busy_after got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        load_student();
        run_stream(30, 600);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got no done want done"); end
        n_checks++; if (got_q.size() != 7) begin n_fail++; $display("FAIL bp_len got %0d want 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (hold_errs != 0) begin n_fail++; $display("FAIL bp_hold got %0d changes while stalled want 0", hold_errs); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", done_pulses); end
        n_checks++; if (end_count !== 5'd7) begin n_fail++; $display("FAIL bp_count got %0d want 7", end_count); end
    endtask

    task automatic test_full_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h41 + 8'(i);
        run_stream(100, 60);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
        n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL full_len got %0d want 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== 8'h41 + 8'(i)) begin n_fail++; $display("FAIL full_byte%0d got %0h want %0h", i, got_q[i], 8'h41 + 8'(i)); end
        end
        // start cycle + 32 fetch/present cycles, done is the 34th cycle
        n_checks++; if (done_edge != 33) begin n_fail++; $display("FAIL full_done_edge got %0d want 33", done_edge); end
        n_checks++; if (end_count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", end_count); end
        n_checks++; if (end_addr !== 4'd15) begin n_fail++; $display("FAIL full_addr got %0d want 15", end_addr); end
        n_checks++; if (rom_addr !== 4'd15) begin n_fail++; $display("FAIL full_no_wrap got %0d want 15", rom_addr); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL full_done_pulses got %0d want 1", done_pulses); end
    endtask

    task automatic test_empty_string();
        for (int i = 0; i < 16; i++) rom[i] = 8'h33;
        rom[0] = 8'h00;
        run_stream(100, 20);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL empty_timeout got no done want done"); end
        n_checks++; if (done_edge != 2) begin n_fail++; $display("FAIL empty_done_edge got %0d want 2", done_edge); end
        n_checks++; if (first_valid_edge != -1) begin n_fail++; $display("FAIL empty_valid got edge %0d want never", first_valid_edge); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL empty_len got %0d want 0", got_q.size()); end
        n_checks++; if (end_count !== 5'd0) begin n_fail++; $display("FAIL empty_count got %0d want 0", end_count); end
    endtask

    task automatic test_abort();
        int nvalid;
        bit hit;
        bit saw_done;
        load_student();
        out_ready = 1'b1;
        nvalid = 0;
        hit = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 1; e <= 40 && !hit; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid) begin
                nvalid++;
                if (nvalid == 3) begin
                    abort = 1'b1;
                    hit = 1'b1;
                end
            end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach got %0d valids want 3", nvalid); end
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state got %0d want IDLE", dbg_state); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", out_valid); end
        n_checks++; if (char_count !== 5'd2) begin n_fail++; $display("FAIL abort_count got %0d want 2", char_count); end
        saw_done = done;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done got done=1 want 0"); end
        out_ready = 1'b0;
        run_stream(100, 60);
        n_checks++; if (got_q.size() != 7) begin n_fail++; $display("FAIL restart_len got %0d want 7", got_q.size()); end
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== 8'h53) begin n_fail++; $display("FAIL restart_first got %0h want 53", got_q[0]); end
        end
        n_checks++; if (end_count !== 5'd7) begin n_fail++; $display("FAIL restart_count got %0d want 7", end_count); end
        // start and abort together while idle: start wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (dbg_state !== ST_FETCH) begin n_fail++; $display("FAIL start_abort_idle got %0d want FETCH", dbg_state); end
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_fetch got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        load_student();
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            start = (e == 4 || e == 5);
            if (e == 5) begin
                n_checks++; if (char_count !== 5'd2 || rom_addr !== 4'd2) begin n_fail++; $display("FAIL busy_start got count %0d addr %0d want 2 2", char_count, rom_addr); end
            end
            if (e == 6) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin n_fail++; $display("FAIL busy_start_byte got v%b %0h want v1 55", out_valid, out_data); end
            end
            if (e == 7) begin
                n_checks++; if (dbg_state !== ST_FETCH || rom_addr !== 4'd3) begin n_fail++; $display("FAIL pre_reset got state %0d addr %0d want FETCH 3", dbg_state, rom_addr); end
                rst_n = 1'b0;
                #2;
                n_checks++; if (rom_addr !== 4'd0 || char_count !== 5'd0) begin n_fail++; $display("FAIL midreset_addr_count got %0d %0d want 0 0", rom_addr, char_count); end
                n_checks++; if (out_data !== 8'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_data got v%b %0h want v0 0", out_valid, out_data); end
                n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_status got busy %b done %b want 0 0", busy, done); end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h53) begin n_fail++; $display("FAIL stall_hold got v%b %0h want v1 53", out_valid, out_data); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid_drop got %b want 0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_student();
        test_backpressure();
        test_full_rom();
        test_empty_string();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no end of test want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
